vga_timing_counter: RTL and testbench
=====================================

# vga_timing_counter

Free-running VGA raster counter that produces the registered horizontal and vertical pixel counts for the display pipeline. It sits directly upstream of the horizontal and vertical sync generators and the pixel renderer, which decode `hCount`/`vCount`. The block also provides active-video, line-end and frame-start strobes. A run/drain state machine starts and stops the raster only on frame boundaries.

## Interface
Parameters:
- `HPIXEL`, 640: visible pixels per line.
- `H_FRONT_PORCH`, 16: horizontal front porch, in pixels.
- `H_SYNC_PULSE`, 96: horizontal sync width, in pixels.
- `H_BACK_PORCH`, 48: horizontal back porch, in pixels.
- `VPIXEL`, 480: visible lines per frame.
- `V_FRONT_PORCH`, 10: vertical front porch, in lines.
- `V_SYNC_PULSE`, 2: vertical sync width, in lines.
- `V_BACK_PORCH`, 33: vertical back porch, in lines.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `pix_en`, in, 1: pixel tick enable; the counters advance only when it is 1.
- `run`, in, 1: request raster output; level-sensitive.
- `hCount`, out, 12: horizontal position, 0..H_TOTAL-1.
- `vCount`, out, 12: vertical position, 0..V_TOTAL-1.
- `active`, out, 1: current position is in the visible area.
- `line_end`, out, 1: one-clk strobe after each horizontal wrap.
- `frame_start`, out, 1: one-clk strobe at the start of each frame.
- `running`, out, 1: state is not IDLE.

## Operation
- H_TOTAL = sum of the four H parameters (800 by default). V_TOTAL = sum of the four V parameters (525 by default). Both totals must be at most 4095.
- The tick equals `pix_en`; see Configuration for the alternative.
- State machine:
  - IDLE → RUN on any clk with `run`=1.
  - RUN → DRAIN when `run`=0.
  - DRAIN → RUN when `run`=1; the raster continues with no discontinuity.
  - DRAIN → IDLE on the final tick of a frame, i.e. a tick at (H_TOTAL-1, V_TOTAL-1).
- IDLE behaviour: counters are held at (0,0) and all strobes are 0.
- RUN/DRAIN behaviour, on each tick:
  - `hCount` increments by 1.
  - At `hCount`=H_TOTAL-1, `hCount` wraps to 0 and `vCount` increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
- `active` = (`hCount` < HPIXEL) && (`vCount` < VPIXEL) && `running`. It is decoded from the registered counts and is therefore aligned with them.
- `line_end` is registered. It is 1 for exactly one clk, the cycle in which `hCount` first shows 0 after a horizontal wrap.
- `frame_start` is registered. It is 1 for exactly one clk in two cases:
  - the first cycle in RUN after IDLE, with counts at (0,0);
  - the cycle after a frame wrap, but only if the next state is RUN.
  - A frame wrap that ends DRAIN produces no `frame_start`.
- Strobes last one clk regardless of the tick rate. A tick while `pix_en` is held high never stretches a strobe.

## Timing
- Reset values: `hCount`=0, `vCount`=0, `active`=0, `line_end`=0, `frame_start`=0, `running`=0, state IDLE.
- Latency:
  - `run` rising in IDLE: `running`=1 and `frame_start`=1 on the next clk edge.
  - First count advance: on the first tick after that edge.
  - Counter update: the same edge as the tick.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous), with no clk edge needed.
- `run` dropping and re-rising within one frame leaves the counters uninterrupted.

## Configuration
- Macro: `VGA_PIX_DIV_EN`.
- Defined:
  - `pix_en` is ignored.
  - An internal 2-bit divider generates the tick, and the tick is 1 when the divider equals 3, so one tick every 4 clks.
  - The divider is cleared by reset and held at 0 in IDLE.
  - It free-runs in RUN and DRAIN.
  - The first tick occurs 4 clks after entering RUN.
- Undefined: tick = `pix_en`; no divider logic.

## Test plan
- Reset, then `run`=1 and `pix_en`=1 → `frame_start` pulses once, and `hCount` counts 0..799. On tick 800, `hCount`=0, `vCount`=1, and `line_end` pulses for one clk.
- Run 420000 ticks → counts return to (0,0), `frame_start` pulses for exactly one clk, and `line_end` pulses in the same cycle.
- Active-window boundaries:
  - (639,0) → `active`=1.
  - (640,0) → `active`=0.
  - (0,479) → `active`=1.
  - (0,480) → `active`=0.
  - In IDLE → `active`=0.
- `run`=0 at `vCount`=100 → counting continues to (799,524), then IDLE at (0,0), `running`=0, and no `frame_start`. Repeat with `run`=1 again at `vCount`=300 → the frame completes seamlessly and `frame_start` pulses at the wrap.
- `pix_en` high every 3rd clk → counts advance only on enabled clks and strobes last one clk. With `VGA_PIX_DIV_EN` → one advance every 4 clks, independent of `pix_en`.
- Assert `rst_n`=0 asynchronously at (300,200) → all outputs go to 0 before the next clk edge. Release it with `run`=1 → a normal restart from (0,0).

Source files
------------

// File: rtl/vga_timing_counter.sv
// Free-running VGA raster counter with run/drain sequencing on frame boundaries.
// Optional build macro VGA_PIX_DIV_EN: internal divide-by-4 tick replaces pix_en.
//
// state | meaning
// IDLE  | counters held at (0,0), strobes low, waiting for run
// RUN   | raster advancing on each tick
// DRAIN | run released; finish current frame, then return to IDLE
module vga_timing_counter #(
   parameter int HPIXEL        = 640,
   parameter int H_FRONT_PORCH = 16,
   parameter int H_SYNC_PULSE  = 96,
   parameter int H_BACK_PORCH  = 48,
   parameter int VPIXEL        = 480,
   parameter int V_FRONT_PORCH = 10,
   parameter int V_SYNC_PULSE  = 2,
   parameter int V_BACK_PORCH  = 33
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_en,
   input  logic        run,
   output logic [11:0] hCount,
   output logic [11:0] vCount,
   output logic        active,
   output logic        line_end,
   output logic        frame_start,
   output logic        running
);

   localparam int H_TOTAL = HPIXEL + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int V_TOTAL = VPIXEL + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_VIS  = 12'(HPIXEL);
   localparam logic [11:0] V_VIS  = 12'(VPIXEL);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;
   logic   tick;
   logic   h_last;
   logic   frame_last;

`ifdef VGA_PIX_DIV_EN
   logic [1:0] div;
   logic       unused_pix_en;

   assign unused_pix_en = pix_en;

   // Cleared in IDLE so the first tick lands exactly 4 clks after entering RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= 2'd0;
      end else if (state == IDLE) begin
         div <= 2'd0;
      end else begin
         div <= div + 2'd1;
      end
   end

   assign tick = (state != IDLE) && (div == 2'd3);
`else
   assign tick = pix_en;
`endif

   assign h_last     = (hCount == H_LAST);
   assign frame_last = h_last && (vCount == V_LAST);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = run ? RUN : IDLE;
         RUN:     state_nx = run ? RUN : DRAIN;
         DRAIN: begin
            if (run)                     state_nx = RUN;
            else if (tick && frame_last) state_nx = IDLE;
            else                         state_nx = DRAIN;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         hCount      <= 12'd0;
         vCount      <= 12'd0;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
         running     <= 1'b0;
      end else begin
         state       <= state_nx;
         running     <= (state_nx != IDLE);
         line_end    <= 1'b0;
         frame_start <= 1'b0;
         if (state == IDLE) begin
            hCount      <= 12'd0;
            vCount      <= 12'd0;
            frame_start <= run;
         end else if (tick) begin
            if (h_last) begin
               hCount   <= 12'd0;
               vCount   <= (vCount == V_LAST) ? 12'd0 : vCount + 12'd1;
               // A wrap that drops us into IDLE must leave all strobes low.
               line_end    <= (state_nx != IDLE);
               frame_start <= (vCount == V_LAST) && (state_nx == RUN);
            end else begin
               hCount <= hCount + 12'd1;
            end
         end
      end
   end

   assign active = running && (hCount < H_VIS) && (vCount < V_VIS);

endmodule

// File: tb/tb_vga_timing_counter.sv
// Scoreboard bench for vga_timing_counter using a small raster and a frame-index reference model.
module tb_vga_timing_counter;

   localparam int HP  = 20;
   localparam int HFP = 2;
   localparam int HSY = 3;
   localparam int HBP = 3;
   localparam int VP  = 12;
   localparam int VFP = 2;
   localparam int VSY = 1;
   localparam int VBP = 3;
   localparam int HT  = HP + HFP + HSY + HBP;
   localparam int VT  = VP + VFP + VSY + VBP;
   localparam int FT  = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_en = 1'b0;
   logic        run = 1'b0;
   logic [11:0] hCount;
   logic [11:0] vCount;
   logic        active;
   logic        line_end;
   logic        frame_start;
   logic        running;

   always #5 clk = ~clk;

   vga_timing_counter #(
      .HPIXEL(HP), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSY), .H_BACK_PORCH(HBP),
      .VPIXEL(VP), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSY), .V_BACK_PORCH(VBP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run),
      .hCount(hCount), .vCount(vCount), .active(active),
      .line_end(line_end), .frame_start(frame_start), .running(running)
   );

   typedef struct {
      int h;
      int v;
      bit act;
      bit le;
      bit fs;
      bit rn;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0 idle, 1 run, 2 drain; position is a linear index into the frame.
   int m_mode = 0;
   int m_pos  = 0;
   int m_k    = 0;
   bit m_le   = 0;
   bit m_fs   = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit pe, input bit rst);
      bit tk;
      bit fin;
      int nm;
      if (rst) begin
         m_mode = 0; m_pos = 0; m_k = 0; m_le = 0; m_fs = 0;
      end else if (m_mode == 0) begin
         m_le = 0; m_fs = r; m_pos = 0; m_k = 0;
         if (r) m_mode = 1;
      end else begin
`ifdef VGA_PIX_DIV_EN
         tk = (m_k % 4) == 3;
         m_k++;
`else
         tk = pe;
`endif
         fin = tk && (m_pos == FT - 1);
         if (r) nm = 1;
         else if (m_mode == 2 && fin) nm = 0;
         else nm = 2;
         if (tk) m_pos = (m_pos + 1) % FT;
         m_le   = tk && (m_pos % HT == 0) && (nm != 0);
         m_fs   = fin && (nm == 1);
         m_mode = nm;
         if (nm == 0) m_k = 0;
      end
   endtask

   function automatic exp_t expect_now();
      exp_t e;
      e.h   = m_pos % HT;
      e.v   = m_pos / HT;
      e.rn  = (m_mode != 0);
      e.act = e.rn && (e.h < HP) && (e.v < VP);
      e.le  = m_le;
      e.fs  = m_fs;
      return e;
   endfunction

   task automatic cyc(input bit r, input bit pe, input bit rst);
      @(negedge clk);
      rst_n  = !rst;
      run    = r;
      pix_en = pe;
      model_step(r, pe, rst);
      q.push_back(expect_now());
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("hCount", int'(hCount), mon_e.h);
            chk("vCount", int'(vCount), mon_e.v);
            chk("active", int'(active), int'(mon_e.act));
            chk("line_end", int'(line_end), int'(mon_e.le));
            chk("frame_start", int'(frame_start), int'(mon_e.fs));
            chk("running", int'(running), int'(mon_e.rn));
         end
      end
   end

   initial begin
      bit r;
      repeat (3) cyc(0, 0, 1);
      repeat (4) cyc(0, 1, 0);

      // Full frame plus two lines at one tick per clk.
      for (int i = 0; i < FT + 2 * HT; i++) cyc(1, 1, 0);

      // Release run mid-frame; raster drains to end of frame then idles.
      for (int i = 0; i < FT && (m_pos / HT) != 5; i++) cyc(1, 1, 0);
      for (int i = 0; i < 2 * FT && m_mode != 0; i++) cyc(0, 1, 0);
      if (m_mode != 0) begin
         errors++;
         $display("FAIL drain_bound: mode %0d expected 0", m_mode);
      end
      repeat (5) cyc(0, 1, 0);

      // Drop and re-raise run within one frame; frame completes seamlessly.
      for (int i = 0; i < FT && (m_pos / HT) < 3; i++) cyc(1, 1, 0);
      for (int i = 0; i < FT && (m_pos / HT) < 8; i++) cyc(0, 1, 0);
      for (int i = 0; i < FT + HT; i++) cyc(1, 1, 0);

      // Sparse tick: one enable every third clk.
      for (int i = 0; i < 3 * FT + 30; i++) cyc(1, (i % 3) == 2, 0);

      // Randomized run/pix_en traffic.
      r = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 1499) == 0) r = ~r;
         cyc(r, $urandom_range(0, 3) != 0, 0);
      end

      // Asynchronous reset mid-frame, between clk edges.
      for (int i = 0; i < 2 * FT && m_mode == 0; i++) cyc(1, 1, 0);
      repeat ($urandom_range(HT, 6 * HT)) cyc(1, 1, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_hCount", int'(hCount), 0);
      chk("async_rst_vCount", int'(vCount), 0);
      chk("async_rst_active", int'(active), 0);
      chk("async_rst_line_end", int'(line_end), 0);
      chk("async_rst_frame_start", int'(frame_start), 0);
      chk("async_rst_running", int'(running), 0);
      repeat (2) cyc(0, 0, 1);
      for (int i = 0; i < 3 * HT; i++) cyc(1, 1, 0);

      repeat (2) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
